// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with 2-bit saturating direction counters.
// Lookup is combinational on pc_f; execute-stage resolutions update one entry per clock.
module branch_predictor #(
  parameter int IDX_W = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_f,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic [2:0]  upd_br_type,
  input  logic        upd_taken,
  input  logic [31:0] upd_target,
  input  logic        upd_pred_taken,
  input  logic [31:0] upd_pred_target,
  output logic        mispredict,
  output logic [15:0] mispredict_cnt
);

  localparam int ENTRIES = 1 << IDX_W;
  localparam int TAG_W   = 30 - IDX_W;

  localparam logic [1:0] CTR_SN = 2'b00;
  localparam logic [1:0] CTR_WN = 2'b01;
  localparam logic [1:0] CTR_WT = 2'b10;
  localparam logic [1:0] CTR_ST = 2'b11;

  logic              valid_q  [ENTRIES];
  logic [TAG_W-1:0]  tag_q    [ENTRIES];
  logic [31:0]       target_q [ENTRIES];
  logic [1:0]        ctr_q    [ENTRIES];
  logic [15:0]       cnt_q, cnt_d;

  logic [IDX_W-1:0]  fetch_idx, upd_idx;
  logic [TAG_W-1:0]  fetch_tag, upd_tag;
  logic              fetch_hit, upd_hit, upd_active, upd_jump;
  logic              entry_we;
  logic [1:0]        ctr_d;
  logic [31:0]       target_d;

  // Low PC bits never take part in indexing or tagging.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{pc_f[1:0], upd_pc[1:0]};

  assign fetch_idx = pc_f[IDX_W+1:2];
  assign fetch_tag = pc_f[31:IDX_W+2];
  assign upd_idx   = upd_pc[IDX_W+1:2];
  assign upd_tag   = upd_pc[31:IDX_W+2];

  always_comb begin
    fetch_hit   = valid_q[fetch_idx] && (tag_q[fetch_idx] == fetch_tag);
    pred_taken  = fetch_hit && ctr_q[fetch_idx][1];
    pred_target = pred_taken ? target_q[fetch_idx] : pc_f + 32'd4;
  end

  // Next state for the single entry addressed by the resolving instruction.
  always_comb begin
    upd_active = upd_valid && (upd_br_type != 3'b000);
    upd_jump   = (upd_br_type == 3'b111);
    upd_hit    = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
    entry_we   = 1'b0;
    ctr_d      = ctr_q[upd_idx];
    target_d   = target_q[upd_idx];
    if (upd_active) begin
      if (upd_jump) begin
        entry_we = 1'b1;
        ctr_d    = CTR_ST;
        target_d = upd_target;
      end else if (upd_hit) begin
        entry_we = 1'b1;
        if (upd_taken) begin
          ctr_d    = (ctr_q[upd_idx] == CTR_ST) ? CTR_ST : ctr_q[upd_idx] + 2'd1;
          target_d = upd_target;
        end else begin
          ctr_d = (ctr_q[upd_idx] == CTR_SN) ? CTR_SN : ctr_q[upd_idx] - 2'd1;
        end
      end else if (upd_taken) begin
        entry_we = 1'b1;
        ctr_d    = CTR_WT;
        target_d = upd_target;
      end
    end
  end

  always_comb begin
    mispredict = upd_active &&
                 ((upd_taken != upd_pred_taken) ||
                  (upd_taken && (upd_target != upd_pred_target)));
    cnt_d = (mispredict && (cnt_q != 16'hFFFF)) ? cnt_q + 16'd1 : cnt_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= CTR_WN;
      end
      cnt_q <= '0;
    end else begin
      if (entry_we) begin
        valid_q[upd_idx]  <= 1'b1;
        tag_q[upd_idx]    <= upd_tag;
        target_q[upd_idx] <= target_d;
        ctr_q[upd_idx]    <= ctr_d;
      end
      cnt_q <= cnt_d;
    end
  end

  assign mispredict_cnt = cnt_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench for branch_predictor: stimulus pushes expectations from a
// behavioural table model, a negedge monitor pops and compares them.
module tb_branch_predictor;

  localparam int IDX_W   = 4;
  localparam int ENTRIES = 16;

  logic        clk;
  logic        rst;
  logic [31:0] pc_f;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic [2:0]  upd_br_type;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        upd_pred_taken;
  logic [31:0] upd_pred_target;
  logic        mispredict;
  logic [15:0] mispredict_cnt;

  int checkCount = 0;
  int failCount  = 0;
  int stepNum    = 0;

  typedef struct {
    logic        predTaken;
    logic [31:0] predTarget;
    logic        mispredict;
    logic [15:0] cnt;
    int          step;
  } expect_t;

  expect_t sbQ[$];

  // Reference table: what each slot remembers, in plain integer terms.
  bit          mValid  [ENTRIES];
  logic [31:0] mTag    [ENTRIES];
  logic [31:0] mTarget [ENTRIES];
  int          mCtr    [ENTRIES];
  int          mCnt;

  branch_predictor #(.IDX_W(IDX_W)) dut (
    .clk            (clk),
    .rst            (rst),
    .pc_f           (pc_f),
    .pred_taken     (pred_taken),
    .pred_target    (pred_target),
    .upd_valid      (upd_valid),
    .upd_pc         (upd_pc),
    .upd_br_type    (upd_br_type),
    .upd_taken      (upd_taken),
    .upd_target     (upd_target),
    .upd_pred_taken (upd_pred_taken),
    .upd_pred_target(upd_pred_target),
    .mispredict     (mispredict),
    .mispredict_cnt (mispredict_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int idxOf(input logic [31:0] pc);
    return int'((pc >> 2) % 32'd16);
  endfunction

  function automatic logic [31:0] tagOf(input logic [31:0] pc);
    return pc >> (IDX_W + 2);
  endfunction

  function automatic void modelReset();
    for (int i = 0; i < ENTRIES; i++) begin
      mValid[i]  = 1'b0;
      mTag[i]    = 32'd0;
      mTarget[i] = 32'd0;
      mCtr[i]    = 1;
    end
    mCnt = 0;
  endfunction

  function automatic logic modelPredTaken(input logic [31:0] pc);
    int i;
    i = idxOf(pc);
    return mValid[i] && (mTag[i] == tagOf(pc)) && (mCtr[i] >= 2);
  endfunction

  function automatic logic [31:0] modelPredTarget(input logic [31:0] pc);
    return modelPredTaken(pc) ? mTarget[idxOf(pc)] : pc + 32'd4;
  endfunction

  function automatic logic modelMispredict(input logic uv, input logic [2:0] ty, input logic ut,
                                           input logic [31:0] utgt, input logic upt,
                                           input logic [31:0] uptgt);
    if (!uv || ty == 3'd0) return 1'b0;
    return (ut != upt) || (ut && utgt != uptgt);
  endfunction

  function automatic void modelUpdate(input logic uv, input logic [31:0] upc, input logic [2:0] ty,
                                      input logic ut, input logic [31:0] utgt, input logic mis);
    int  i;
    bit  hit;
    i   = idxOf(upc);
    hit = mValid[i] && (mTag[i] == tagOf(upc));
    if (uv && ty != 3'd0) begin
      if (ty == 3'd7) begin
        mValid[i] = 1'b1; mTag[i] = tagOf(upc); mTarget[i] = utgt; mCtr[i] = 3;
      end else if (hit) begin
        if (ut) begin
          mCtr[i]    = (mCtr[i] + 1 > 3) ? 3 : mCtr[i] + 1;
          mTarget[i] = utgt;
        end else begin
          mCtr[i] = (mCtr[i] - 1 < 0) ? 0 : mCtr[i] - 1;
        end
      end else if (ut) begin
        mValid[i] = 1'b1; mTag[i] = tagOf(upc); mTarget[i] = utgt; mCtr[i] = 2;
      end
    end
    if (mis && mCnt < 65535) mCnt = mCnt + 1;
  endfunction

  // One cycle: drive inputs just after the edge, record what must be seen this cycle,
  // then advance the model to what the next edge commits.
  task automatic applyStimulus(input logic r, input logic uv, input logic [31:0] upc,
                               input logic [2:0] ty, input logic ut, input logic [31:0] utgt,
                               input logic upt, input logic [31:0] uptgt, input logic [31:0] fpc);
    expect_t e;
    @(posedge clk);
    #1;
    rst             = r;
    upd_valid       = uv;
    upd_pc          = upc;
    upd_br_type     = ty;
    upd_taken       = ut;
    upd_target      = utgt;
    upd_pred_taken  = upt;
    upd_pred_target = uptgt;
    pc_f            = fpc;
    if (r) modelReset();
    stepNum++;
    e.predTaken  = modelPredTaken(fpc);
    e.predTarget = modelPredTarget(fpc);
    e.mispredict = modelMispredict(uv, ty, ut, utgt, upt, uptgt);
    e.cnt        = mCnt[15:0];
    e.step       = stepNum;
    sbQ.push_back(e);
    if (!r) modelUpdate(uv, upc, ty, ut, utgt, e.mispredict);
  endtask

  task automatic idle(input logic [31:0] fpc);
    applyStimulus(1'b0, 1'b0, 32'd0, 3'd0, 1'b0, 32'd0, 1'b0, 32'd0, fpc);
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp,
                             input int step);
    checkCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s step=%0d got=%h expected=%h", name, step, act, exp);
    end
  endtask

  function automatic logic [31:0] randPc();
    logic [31:0] base;
    case ($urandom_range(0, 5))
      0:       base = 32'h100;
      1:       base = 32'h140;
      2:       base = 32'h180;
      3:       base = 32'h200;
      4:       base = 32'h244;
      default: base = $urandom() & 32'h0000_FFFC;
    endcase
    return base | 32'($urandom_range(0, 3));
  endfunction

  // Monitor: the design is always presenting a lookup, so every cycle with a
  // pending expectation is compared half a period after the inputs settle.
  always @(negedge clk) begin
    if (sbQ.size() > 0) begin
      expect_t e;
      e = sbQ.pop_front();
      checkOutput("pred_taken",     {31'd0, pred_taken}, {31'd0, e.predTaken},  e.step);
      checkOutput("pred_target",    pred_target,         e.predTarget,          e.step);
      checkOutput("mispredict",     {31'd0, mispredict}, {31'd0, e.mispredict}, e.step);
      checkOutput("mispredict_cnt", {16'd0, mispredict_cnt}, {16'd0, e.cnt},    e.step);
    end
  end

  initial begin
    logic [31:0] upc, fpc, utgt, uptgt;
    logic [2:0]  ty;
    logic        uv, ut, upt, r;

    rst = 1'b1; pc_f = 32'h100; upd_valid = 1'b0; upd_pc = '0; upd_br_type = '0;
    upd_taken = 1'b0; upd_target = '0; upd_pred_taken = 1'b0; upd_pred_target = '0;
    modelReset();

    // Reset, with an update that must be discarded, then the reset-state lookup.
    applyStimulus(1'b1, 1'b1, 32'h100, 3'd1, 1'b1, 32'h80, 1'b0, 32'h104, 32'h100);
    idle(32'h100);

    // Allocation by a mispredicted taken conditional.
    applyStimulus(1'b0, 1'b1, 32'h100, 3'd1, 1'b1, 32'h80, 1'b0, 32'h104, 32'h100);
    idle(32'h100);

    // Counter walk down to SN, saturation, then back up.
    applyStimulus(1'b0, 1'b1, 32'h100, 3'd1, 1'b0, 32'h0, 1'b1, 32'h80, 32'h100);
    applyStimulus(1'b0, 1'b1, 32'h100, 3'd2, 1'b0, 32'h0, 1'b0, 32'h0, 32'h100);
    applyStimulus(1'b0, 1'b1, 32'h100, 3'd3, 1'b0, 32'h0, 1'b0, 32'h0, 32'h100);
    applyStimulus(1'b0, 1'b1, 32'h100, 3'd1, 1'b1, 32'h90, 1'b0, 32'h104, 32'h100);
    applyStimulus(1'b0, 1'b1, 32'h100, 3'd1, 1'b1, 32'h90, 1'b0, 32'h104, 32'h100);
    idle(32'h100);

    // Aliasing tag replaces the occupant of the shared index.
    applyStimulus(1'b0, 1'b1, 32'h140, 3'd4, 1'b1, 32'h500, 1'b0, 32'h144, 32'h140);
    idle(32'h140);
    idle(32'h100);

    // Unconditional jump; same-cycle lookup sees the old miss.
    applyStimulus(1'b0, 1'b1, 32'h200, 3'd7, 1'b1, 32'h400, 1'b0, 32'h204, 32'h200);
    idle(32'h200);

    // Randomised traffic over a small set of colliding PCs.
    for (int n = 0; n < 600; n++) begin
      r    = ($urandom_range(0, 99) == 0);
      uv   = ($urandom_range(0, 3) != 0);
      upc  = randPc();
      ty   = 3'($urandom_range(0, 7));
      ut   = 1'($urandom_range(0, 1));
      utgt = ($urandom_range(0, 1) == 1) ? 32'h80 : ($urandom() & 32'h0000_FFFC);
      if ($urandom_range(0, 1) == 1) begin
        upt   = modelPredTaken(upc);
        uptgt = modelPredTarget(upc);
      end else begin
        upt   = 1'($urandom_range(0, 1));
        uptgt = ($urandom_range(0, 1) == 1) ? utgt : $urandom();
      end
      fpc = ($urandom_range(0, 1) == 1) ? upc : randPc();
      applyStimulus(r, uv, upc, ty, ut, utgt, upt, uptgt, fpc);
    end

    // Drive the miss counter into saturation and one past it.
    for (int n = 0; n < 65537; n++) begin
      applyStimulus(1'b0, 1'b1, 32'h300, 3'd1, 1'b1, 32'h80, 1'b0, 32'h0, randPc());
    end
    idle(32'h300);

    // Reset raised mid-cycle must clear the counter before any edge.
    applyStimulus(1'b1, 1'b0, 32'd0, 3'd0, 1'b0, 32'd0, 1'b0, 32'd0, 32'h300);
    idle(32'h300);

    for (int i = 0; i < 10 && sbQ.size() > 0; i++) @(negedge clk);
    #1;
    if (sbQ.size() != 0) begin
      checkCount++;
      failCount++;
      $display("[TB] FAIL drain pending=%0d required=0", sbQ.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
